// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep stimulus generator and self-checker for an N-input reduction gate under test.
// Optional build macro STOP_ON_FAIL_EN ends the sweep at the first mismatching pattern.
module gate_sweep_checker #(
    parameter int N    = 3,
    parameter int HOLD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         dut_out,
    output logic [N-1:0] pattern_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         fail_seen
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int              CW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD - 1);
    localparam logic [N:0]      ERR_MAX   = {1'b1, {N{1'b0}}};

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   hold_cnt;
    logic [1:0]      mode_q;
    logic            expected;
    logic            mismatch;
    logic            last_pattern;
    logic            finish;
    logic            start_ok;
    logic            hold_wrap;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Expected reduction, sweep termination and next-state selection
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        hold_wrap = (hold_cnt == HOLD_LAST);
        expected  = 1'b0;
        case (mode_q)
            2'd0: expected = &pattern_out;
            2'd1: expected = |pattern_out;
            2'd2: expected = ^pattern_out;
            2'd3: expected = ~&pattern_out;
            default: expected = 1'b0;
        endcase
        mismatch     = (state_q == SAMPLE) && (dut_out != expected);
        last_pattern = &pattern_out;
`ifdef STOP_ON_FAIL_EN
        finish       = last_pattern || mismatch;
`else
        finish       = last_pattern;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_wrap) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = finish ? DONE : DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sweep datapath: pattern, hold timing, mismatch bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_out <= '0;
            err_count   <= '0;
            first_fail  <= '0;
            fail_seen   <= 1'b0;
            hold_cnt    <= '0;
            mode_q      <= 2'd0;
        end else if (start_ok) begin
            mode_q      <= mode;
            pattern_out <= '0;
            err_count   <= '0;
            first_fail  <= '0;
            fail_seen   <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            case (state_q)
                DRIVE: begin
                    hold_cnt <= hold_wrap ? '0 : hold_cnt + CW'(1);
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + (N+1)'(1);
                        end
                        if (!fail_seen) begin
                            first_fail <= pattern_out;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (!finish) begin
                        pattern_out <= pattern_out + N'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done = (state_q == DONE);
    assign pass = (state_q == DONE) && (err_count == '0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized self-checking bench for gate_sweep_checker: two instances (HOLD=2, HOLD=1)
// checked each cycle against a timeline model of the sweep, plus hand-computed pins.
module tb_gate_sweep_checker;

    localparam int N = 3;
    localparam int P = 1 << N;

    typedef struct packed {
        logic [N-1:0] pat;
        logic         busy;
        logic         done;
        logic         pass;
        logic [N:0]   err;
        logic [N-1:0] ff;
        logic         fs;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic          dut_out [2];
    logic [N-1:0]  pat     [2];
    logic          busy    [2];
    logic          done    [2];
    logic          pass    [2];
    logic [N:0]    err     [2];
    logic [N-1:0]  ff      [2];
    logic          fs      [2];

    int            gate_sel;
    logic [P-1:0]  fault_mask;
    int            n_compared   = 0;
    int            n_mismatched = 0;

    bit            run [2] = '{1'b0, 1'b0};
    int            k   [2] = '{0, 0};
    logic [P-1:0]  mm  [2] = '{'0, '0};
    exp_t          mdl_e;
    exp_t          cmp_e;

    gate_sweep_checker #(.N(N), .HOLD(2)) u_dut_h2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(dut_out[0]),
        .pattern_out(pat[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .first_fail(ff[0]), .fail_seen(fs[0])
    );

    gate_sweep_checker #(.N(N), .HOLD(1)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(dut_out[1]),
        .pattern_out(pat[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .first_fail(ff[1]), .fail_seen(fs[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int hold_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Emulated gate under test: 0..3 ideal AND/OR/XOR/NAND, 4/5 stuck-at, else AND with flipped rows
    function automatic logic gate_fn(input int g, input logic [P-1:0] fm, input int p);
        case (g)
            0: return p == P - 1;
            1: return p != 0;
            2: return logic'($countones(p) % 2);
            3: return p != P - 1;
            4: return 1'b0;
            5: return 1'b1;
            default: return (p == P - 1) ^ fm[p];
        endcase
    endfunction

    function automatic logic ref_fn(input logic [1:0] m, input int p);
        case (m)
            2'd0: return p == P - 1;
            2'd1: return p != 0;
            2'd2: return logic'($countones(p) % 2);
            default: return p != P - 1;
        endcase
    endfunction

    function automatic logic [P-1:0] mismatch_mask(input logic [1:0] m, input int g, input logic [P-1:0] fm);
        logic [P-1:0] r;
        r = '0;
        for (int p = 0; p < P; p++) r[p] = gate_fn(g, fm, p) != ref_fn(m, p);
        return r;
    endfunction

    function automatic int last_pattern_of(input logic [P-1:0] m);
        int stop_p;
        stop_p = P - 1;
`ifdef STOP_ON_FAIL_EN
        for (int q = P - 1; q >= 0; q--) if (m[q]) stop_p = q;
`endif
        return stop_p;
    endfunction

    function automatic int exp_latency(input int h, input logic [P-1:0] m);
        return (last_pattern_of(m) + 1) * (h + 1) + 1;
    endfunction

    // Outputs k edges after the accepted start edge: every pattern occupies h+1 cycles
    function automatic exp_t model_out(input int h, input bit r, input int kk, input logic [P-1:0] m);
        exp_t e;
        int   stop_p, end_k, sampled, cnt, first;
        bit   any;
        e = '0;
        if (!r) return e;
        stop_p  = last_pattern_of(m);
        end_k   = (stop_p + 1) * (h + 1);
        sampled = (kk >= end_k) ? stop_p + 1 : kk / (h + 1);
        cnt = 0; first = 0; any = 1'b0;
        for (int q = 0; q < sampled; q++) begin
            if (m[q]) begin
                cnt++;
                if (!any) begin first = q; any = 1'b1; end
            end
        end
        e.err = (N+1)'(cnt);
        e.ff  = N'(first);
        e.fs  = any;
        if (kk >= end_k) begin
            e.done = 1'b1;
            e.pat  = N'(stop_p);
            e.pass = (cnt == 0);
        end else begin
            e.busy = 1'b1;
            e.pat  = N'(sampled);
        end
        return e;
    endfunction

    always_comb begin
        dut_out[0] = gate_fn(gate_sel, fault_mask, int'(pat[0]));
        dut_out[1] = gate_fn(gate_sel, fault_mask, int'(pat[1]));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                run[i] <= 1'b0;
                k[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mdl_e = model_out(hold_of(i), run[i], k[i], mm[i]);
                if (start && !mdl_e.busy) begin
                    run[i] <= 1'b1;
                    k[i]   <= 0;
                    mm[i]  <= mismatch_mask(mode, gate_sel, fault_mask);
                end else if (run[i] && k[i] < 100000) begin
                    k[i] <= k[i] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            cmp_e = model_out(hold_of(i), run[i], k[i], mm[i]);
            checkOutput($sformatf("pattern_out[h%0d]", hold_of(i)), 32'(pat[i]),  32'(cmp_e.pat));
            checkOutput($sformatf("busy[h%0d]", hold_of(i)),        32'(busy[i]), 32'(cmp_e.busy));
            checkOutput($sformatf("done[h%0d]", hold_of(i)),        32'(done[i]), 32'(cmp_e.done));
            checkOutput($sformatf("pass[h%0d]", hold_of(i)),        32'(pass[i]), 32'(cmp_e.pass));
            checkOutput($sformatf("err_count[h%0d]", hold_of(i)),   32'(err[i]),  32'(cmp_e.err));
            checkOutput($sformatf("first_fail[h%0d]", hold_of(i)),  32'(ff[i]),   32'(cmp_e.ff));
            checkOutput($sformatf("fail_seen[h%0d]", hold_of(i)),   32'(fs[i]),   32'(cmp_e.fs));
        end
    end

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput({tag, "_pattern"}, 32'(pat[i]),  0);
            checkOutput({tag, "_busy"},    32'(busy[i]), 0);
            checkOutput({tag, "_done"},    32'(done[i]), 0);
            checkOutput({tag, "_pass"},    32'(pass[i]), 0);
            checkOutput({tag, "_err"},     32'(err[i]),  0);
            checkOutput({tag, "_ff"},      32'(ff[i]),   0);
            checkOutput({tag, "_fs"},      32'(fs[i]),   0);
        end
    endtask

    // Latencies count clock edges from the cycle start is raised to the first cycle done is seen
    task automatic applyStimulus(input logic [1:0] m, input int g, input logic [P-1:0] fm,
                                 input int extra_at, input int reset_at, input bit check_clear,
                                 output int lat2, output int lat1);
        gate_sel   = g;
        fault_mask = fm;
        mode       = m;
        lat2 = -1;
        lat1 = -1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = (c == extra_at);
            mode  = 2'($urandom);
            if (c == 1 && check_clear) begin
                for (int i = 0; i < 2; i++) begin
                    checkOutput("restart_err_cleared",  32'(err[i]),  0);
                    checkOutput("restart_ff_cleared",   32'(ff[i]),   0);
                    checkOutput("restart_fs_cleared",   32'(fs[i]),   0);
                    checkOutput("restart_busy",         32'(busy[i]), 1);
                end
            end
            if (c == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkAllZero("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done[0] && lat2 < 0) lat2 = c;
            if (done[1] && lat1 < 0) lat1 = c;
            if (lat2 >= 0 && lat1 >= 0) break;
        end
    endtask

    int           l2, l1;
    logic [1:0]   rm;
    int           rg;
    logic [P-1:0] rf;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 2'd0;
        gate_sel   = 0;
        fault_mask = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'd0, 0, '0, 0, 0, 1'b0, l2, l1);
        checkOutput("and_ideal_latency_h2", l2, 25);
        checkOutput("and_ideal_latency_h1", l1, 17);
        checkOutput("and_ideal_pattern",    32'(pat[0]),  7);
        checkOutput("and_ideal_pass",       32'(pass[0]), 1);
        checkOutput("and_ideal_err",        32'(err[0]),  0);
        checkOutput("and_ideal_ff",         32'(ff[0]),   0);

        applyStimulus(2'd0, 4, '0, 0, 0, 1'b0, l2, l1);
        checkOutput("and_stuck0_err",  32'(err[0]),  1);
        checkOutput("and_stuck0_ff",   32'(ff[0]),   7);
        checkOutput("and_stuck0_pass", 32'(pass[0]), 0);
        checkOutput("and_stuck0_fs",   32'(fs[0]),   1);

        applyStimulus(2'd2, 0, '0, 0, 0, 1'b0, l2, l1);
        checkOutput("xor_vs_and_ff",   32'(ff[0]),   1);
        checkOutput("xor_vs_and_pass", 32'(pass[0]), 0);
`ifdef STOP_ON_FAIL_EN
        checkOutput("xor_vs_and_latency_h2", l2, 7);
        checkOutput("xor_vs_and_pattern",    32'(pat[0]), 1);
        checkOutput("xor_vs_and_err",        32'(err[0]), 1);
`else
        checkOutput("xor_vs_and_latency_h2", l2, 25);
        checkOutput("xor_vs_and_err",        32'(err[0]), 3);
`endif

        applyStimulus(2'd1, 1, '0, 5, 0, 1'b0, l2, l1);
        checkOutput("busy_start_latency_h2", l2, 25);
        checkOutput("busy_start_latency_h1", l1, 17);

        applyStimulus(2'd1, 4, '0, 0, 10, 1'b0, l2, l1);
        applyStimulus(2'd1, 1, '0, 0, 0, 1'b0, l2, l1);
        checkOutput("after_reset_latency_h2", l2, 25);
        checkOutput("after_reset_pass",       32'(pass[0]), 1);

        applyStimulus(2'd0, 5, '0, 0, 0, 1'b0, l2, l1);
        applyStimulus(2'd3, 3, '0, 0, 0, 1'b1, l2, l1);
        checkOutput("nand_latency_h1", l1, 17);
        checkOutput("nand_pass_h1",    32'(pass[1]), 1);

        repeat (10) begin
            rm = 2'($urandom);
            rg = $urandom_range(0, 6);
            rf = P'($urandom);
            applyStimulus(rm, rg, rf, ($urandom_range(0, 1) != 0) ? $urandom_range(2, 15) : 0,
                          0, 1'b0, l2, l1);
            checkOutput("random_latency_h2", l2, exp_latency(2, mismatch_mask(rm, rg, rf)));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Exhaustive stimulus generator and self-checker for an N-input reduction gate under test.
- Sweeps every input combination 0 … 2^N−1 on `pattern_out` and holds each pattern for a programmable number of cycles.
- Samples the DUT output and compares it against the expected reduction (AND/OR/XOR/NAND).
- Reports mismatch count, first failing pattern and pass/fail; replaces free-running toggle stimulus in gate-level lab benches.

Parameters:
- N, 3: number of gate inputs and width of the pattern; legal 1..16.
- HOLD, 2: cycles each pattern is driven before sampling; legal ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when IDLE or DONE.
- mode  in  2  expected function: 0=AND, 1=OR, 2=XOR, 3=NAND; latched on accepted start.
- dut_out  in  1  output of the gate under test.
- pattern_out  out  N  stimulus to the DUT inputs; bit 0 toggles fastest.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  high while in DONE.
- pass  out  1  valid while done: 1 iff err_count==0.
- err_count  out  N+1  number of mismatching patterns; saturates at 2^N.
- first_fail  out  N  pattern of the first mismatch; 0 if none.
- fail_seen  out  1  set on the first mismatch of a sweep.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0: pattern_out, busy, done, pass, err_count, first_fail, fail_seen.
  - Internal hold counter = 0; latched mode = 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with start=1:
  - latch mode; clear pattern_out, err_count, first_fail, fail_seen and hold counter; clear done/pass.
  - go to DRIVE.
- start while busy is ignored; a mode change mid-sweep has no effect.
- DRIVE:
  - hold counter increments each cycle.
  - when the counter == HOLD−1: clear the counter and go to SAMPLE.
  - Pattern is therefore stable for HOLD cycles before sampling.
- SAMPLE (one cycle):
  - expected = &pattern_out, |pattern_out, ^pattern_out or ~&pattern_out per latched mode.
  - if dut_out != expected: err_count++ (saturating). If fail_seen==0, first_fail<=pattern_out and fail_seen<=1.
  - if pattern_out == all ones: go to DONE; pattern_out holds its final value.
  - else: pattern_out++ and go to DRIVE.
- DONE: done=1, busy=0, pass=(err_count==0). Remains here until start or reset.
- Latency: from the start edge to done=1 is exactly 2^N·(HOLD+1)+1 cycles. One cycle enters DRIVE; then each pattern takes HOLD+1 cycles.
- Comparison uses only the value sampled in SAMPLE; dut_out is ignored in all other states.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs cleared; no partial result is retained.
- N=1: two patterns; err_count is 2 bits.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE goes straight to DONE. pattern_out holds the failing value, err_count=1, pass=0.
- Not defined: the sweep always covers all 2^N patterns and counts every mismatch.

Test Plan:
- N=3, HOLD=2, mode=AND, ideal AND DUT, start pulse → done after 25 cycles, pass=1, err_count=0, first_fail=0, pattern_out=3'b111.
- N=3, mode=AND, DUT stuck-at-0 → err_count=1, first_fail=3'b111, pass=0, fail_seen=1.
- N=3, mode=XOR, DUT is AND → err_count=3, first_fail=3'b001, pass=0.
  - With STOP_ON_FAIL_EN: done 7 cycles after start, pattern_out=3'b001, err_count=1.
- Mid-sweep checks:
  - start pulses during busy → ignored; sweep completes on the original schedule.
  - rst_n low at cycle 10 → all outputs 0 asynchronously, state IDLE.
  - A fresh start after reset → full sweep.
- N=3, HOLD=1, mode=NAND, ideal NAND DUT → done after 17 cycles, pass=1.
  - Back-to-back start in DONE restarts the sweep; err_count and first_fail are cleared on the start edge.
